// File: rtl/imuldiv_div_port_arbiter_pkg.sv
// Shared definitions for the two-port divider arbiter: FSM encodings, result
// field positions, divide-request function codes and the divide-by-zero result.
package imuldiv_div_port_arbiter_pkg;

    localparam logic IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED = 1'b0;
    localparam logic IMULDIV_DIVREQ_MSG_FUNC_SIGNED   = 1'b1;

    localparam int RESULT_QUOT_LSB = 0;
    localparam int RESULT_QUOT_MSB = 31;
    localparam int RESULT_REM_LSB  = 32;
    localparam int RESULT_REM_MSB  = 63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic        fn;
        logic [31:0] a;
        logic [31:0] b;
    } divreq_msg_t;

    // Divide by zero: quotient all-ones, remainder is the dividend.
    function automatic logic [63:0] divzero_result(input logic [31:0] a);
        logic [63:0] r;
        r = '0;
        r[RESULT_REM_MSB:RESULT_REM_LSB]   = a;
        r[RESULT_QUOT_MSB:RESULT_QUOT_LSB] = 32'hFFFF_FFFF;
        return r;
    endfunction

endpackage

// File: rtl/imuldiv_div_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module imuldiv_div_rr_arb2 (
    input  logic [1:0] vals,
    input  logic       last_grant,
    input  logic       en,
    output logic       grant,
    output logic       grant_val
);

    always_comb begin
        grant_val = en & (|vals);
        if (&vals) grant = ~last_grant;
        else       grant = vals[1];
    end

endmodule

// File: rtl/imuldiv_div_port_arbiter.sv
// Shares one iterative divider between two requester ports, one transaction at
// a time, returning the result to the port that issued it.
// Optional: IMULDIV_DIV_ARB_DIVZERO_BYPASS_EN answers b==0 locally without the divider.
module imuldiv_div_port_arbiter
    import imuldiv_div_port_arbiter_pkg::*;
#(
    parameter logic PRIO_INIT = 1'b0,
    parameter int   CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_msg_fn,
    input  logic [31:0]      req0_msg_a,
    input  logic [31:0]      req0_msg_b,
    input  logic             req0_val,
    output logic             req0_rdy,

    input  logic             req1_msg_fn,
    input  logic [31:0]      req1_msg_a,
    input  logic [31:0]      req1_msg_b,
    input  logic             req1_val,
    output logic             req1_rdy,

    output logic [63:0]      resp0_msg_result,
    output logic             resp0_val,
    input  logic             resp0_rdy,

    output logic [63:0]      resp1_msg_result,
    output logic             resp1_val,
    input  logic             resp1_rdy,

    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,

    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,

    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] busy_cycles
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    divreq_msg_t       cap_q;
    logic [63:0]       result_q;
    logic [CNT_W-1:0]  busy_cycles_q;

    divreq_msg_t [1:0] req_msg;
    logic [1:0]        req_val_v, req_rdy_v, resp_val_v, resp_rdy_v;
    logic              grant, grant_val;
    logic              accept, bypass;

    assign req_msg[0]  = '{fn: req0_msg_fn, a: req0_msg_a, b: req0_msg_b};
    assign req_msg[1]  = '{fn: req1_msg_fn, a: req1_msg_a, b: req1_msg_b};
    assign req_val_v   = {req1_val, req0_val};
    assign resp_rdy_v  = {resp1_rdy, resp0_rdy};

    imuldiv_div_rr_arb2 u_rr_arb (
        .vals       (req_val_v),
        .last_grant (last_grant_q),
        .en         (state_q == ST_IDLE && !reset),
        .grant      (grant),
        .grant_val  (grant_val)
    );

`ifdef IMULDIV_DIV_ARB_DIVZERO_BYPASS_EN
    assign bypass = (req_msg[grant].b == 32'd0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_rdy_v   = '0;
        resp_val_v  = '0;
        divreq_val  = 1'b0;
        divresp_rdy = 1'b0;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_val) begin
                    req_rdy_v[grant] = 1'b1;
                    accept           = 1'b1;
                    state_d          = bypass ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                divreq_val = 1'b1;
                if (divreq_rdy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                divresp_rdy = 1'b1;
                if (divresp_val) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_val_v[owner_q] = 1'b1;
                if (resp_rdy_v[owner_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshakes are masked for the whole reset cycle, even before state clears.
        if (reset) begin
            req_rdy_v   = '0;
            resp_val_v  = '0;
            divreq_val  = 1'b0;
            divresp_rdy = 1'b0;
            accept      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= ~PRIO_INIT;
            owner_q       <= 1'b0;
            cap_q         <= '0;
            result_q      <= '0;
            busy_cycles_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_q        <= req_msg[grant];
                owner_q      <= grant;
                last_grant_q <= grant;
                if (bypass) result_q <= divzero_result(req_msg[grant].a);
            end
            if (state_q == ST_WAIT && divresp_val) result_q <= divresp_msg_result;
            if (state_q != ST_IDLE && busy_cycles_q != '1)
                busy_cycles_q <= busy_cycles_q + 1'b1;
        end
    end

    assign req0_rdy         = req_rdy_v[0];
    assign req1_rdy         = req_rdy_v[1];
    assign resp0_val        = resp_val_v[0];
    assign resp1_val        = resp_val_v[1];
    assign resp0_msg_result = result_q;
    assign resp1_msg_result = result_q;

    assign divreq_msg_fn    = cap_q.fn;
    assign divreq_msg_a     = cap_q.a;
    assign divreq_msg_b     = cap_q.b;

    assign busy             = (state_q != ST_IDLE);
    assign owner            = owner_q;
    assign busy_cycles      = busy_cycles_q;

endmodule

// File: tb/tb_imuldiv_div_port_arbiter.sv
// Directed bench for the two-port divider arbiter with a fixed-latency divider model.
module tb_imuldiv_div_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]        req_val, req_fn, resp_rdy;
    logic [1:0][31:0]  req_a, req_b;
    logic              req0_rdy_w, req1_rdy_w, resp0_val_w, resp1_val_w;
    logic [63:0]       resp0_res_w, resp1_res_w;
    logic [1:0]        req_rdy, resp_val;
    logic [1:0][63:0]  resp_res;
    logic              divreq_fn, divreq_val, divreq_rdy, divresp_val, divresp_rdy;
    logic [31:0]       divreq_a, divreq_b;
    logic [63:0]       divresp_res;
    logic              busy, owner;
    logic [3:0]        busy_cycles;

    assign req_rdy  = {req1_rdy_w, req0_rdy_w};
    assign resp_val = {resp1_val_w, resp0_val_w};
    assign resp_res = {resp1_res_w, resp0_res_w};

    imuldiv_div_port_arbiter #(.PRIO_INIT(1'b0), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_msg_fn(req_fn[0]), .req0_msg_a(req_a[0]), .req0_msg_b(req_b[0]),
        .req0_val(req_val[0]), .req0_rdy(req0_rdy_w),
        .req1_msg_fn(req_fn[1]), .req1_msg_a(req_a[1]), .req1_msg_b(req_b[1]),
        .req1_val(req_val[1]), .req1_rdy(req1_rdy_w),
        .resp0_msg_result(resp0_res_w), .resp0_val(resp0_val_w), .resp0_rdy(resp_rdy[0]),
        .resp1_msg_result(resp1_res_w), .resp1_val(resp1_val_w), .resp1_rdy(resp_rdy[1]),
        .divreq_msg_fn(divreq_fn), .divreq_msg_a(divreq_a), .divreq_msg_b(divreq_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_res), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
        .busy(busy), .owner(owner), .busy_cycles(busy_cycles)
    );

    // Divider model: one op at a time, result valid two cycles after acceptance.
    logic        dm_busy;
    int          dm_cnt;
    logic [63:0] dm_res;
    assign divreq_rdy  = !dm_busy;
    assign divresp_val = dm_busy && dm_cnt == 0;
    assign divresp_res = dm_res;

    function automatic logic [63:0] div_model(input logic fn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (fn) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        return {a % b, a / b};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            dm_busy <= 1'b0;
            dm_cnt  <= 0;
            dm_res  <= '0;
        end else if (divreq_val && divreq_rdy) begin
            dm_busy <= 1'b1;
            dm_cnt  <= 2;
            dm_res  <= div_model(divreq_fn, divreq_a, divreq_b);
        end else if (dm_busy) begin
            if (dm_cnt > 0) dm_cnt <= dm_cnt - 1;
            else if (divresp_rdy) dm_busy <= 1'b0;
        end
    end

    int divreq_cnt = 0, resp1_cnt = 0;
    always @(negedge clk) begin
        if (divreq_val) divreq_cnt <= divreq_cnt + 1;
        if (resp_val[1]) resp1_cnt <= resp1_cnt + 1;
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk(nm, {60'd0, req_rdy, resp_val, divreq_val, divresp_rdy}, 64'd0);
    endtask

    task automatic send(input int p, input logic fn, input logic [31:0] a, input logic [31:0] b, input string nm);
        bit got = 0;
        req_fn[p] = fn; req_a[p] = a; req_b[p] = b; req_val[p] = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (req_rdy[p]) got = 1;
            @(posedge clk);
            @(negedge clk);
        end
        req_val[p] = 1'b0;
        chk({nm, "_accept"}, 64'(got), 64'd1);
    endtask

    task automatic wait_resp(input int p, input logic [63:0] exp, input string nm);
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (resp_val[p]) begin
                got = 1;
                chk({nm, "_res"}, resp_res[p], exp);
                chk({nm, "_owner"}, 64'(owner), 64'(p));
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk({nm, "_resp"}, 64'(got), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic        fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          exp_bc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int r1_snap, dq_snap;
        bit got;
        vecs[0] = '{0, 1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         5};
        vecs[1] = '{1, 1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},  10};
        vecs[2] = '{0, 1'b1, 32'hFFFF_FF9C,  32'd7,          {32'hFFFF_FFFE,  32'hFFFF_FFF2},  15};
        vecs[3] = '{1, 1'b0, 32'hFFFF_FFFF,  32'd2,          {32'd1,          32'h7FFF_FFFF},  15};
        vecs[4] = '{0, 1'b1, 32'hFFFF_FFFF,  32'd2,          {32'hFFFF_FFFF,  32'd0},          -1};
        vecs[5] = '{1, 1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD},  -1};

        reset = 1'b1;
        req_val = '0; req_fn = '0; req_a = '0; req_b = '0; resp_rdy = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        req_val = 2'b11;
        #1 chk_quiet("reset_handshakes");
        req_val = '0;
        reset = 1'b0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_busy_cycles", 64'(busy_cycles), 64'd0);
        chk("reset_owner", 64'(owner), 64'd0);
        @(negedge clk);

        // Single-port transactions; busy_cycles tracks 5 per op and saturates at 15.
        for (int i = 0; i < 6; i++) begin
            r1_snap = resp1_cnt;
            send(vecs[i].port, vecs[i].fn, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            wait_resp(vecs[i].port, vecs[i].exp, $sformatf("vec%0d", i));
            if (vecs[i].exp_bc >= 0)
                chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_cycles), 64'(vecs[i].exp_bc));
            if (vecs[i].port == 0)
                chk($sformatf("vec%0d_no_resp1", i), 64'(resp1_cnt - r1_snap), 64'd0);
        end

        // Simultaneous requests after reset: port 0 first, then strict alternation.
        do_reset();
        req_fn = 2'b01; req_a[0] = 32'hFFFF_FFF9; req_b[0] = 32'd2; req_a[1] = 32'd9; req_b[1] = 32'd3;
        req_val = 2'b11;
        for (int k = 0; k < 10; k++) begin
            int p;
            p = k % 2;
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                #1;
                if (req_rdy != 2'b00) got = 1;
                else begin @(posedge clk); @(negedge clk); end
            end
            chk($sformatf("alt%0d_grant", k), 64'(req_rdy), 64'(2'b01 << p));
            @(posedge clk); @(negedge clk);
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                #1;
                if (resp_val != 2'b00) got = 1;
                else begin @(posedge clk); @(negedge clk); end
            end
            chk($sformatf("alt%0d_respval", k), 64'(resp_val), 64'(2'b01 << p));
            chk($sformatf("alt%0d_res", k), resp_res[p],
                p == 0 ? {32'hFFFF_FFFF, 32'hFFFF_FFFD} : {32'd0, 32'd3});
            @(posedge clk); @(negedge clk);
        end
        req_val = '0;
        @(negedge clk);

        // Response backpressure holds result and blocks the other port.
        resp_rdy[0] = 1'b0;
        send(0, 1'b0, 32'd100, 32'd7, "bp");
        req_fn[1] = 1'b0; req_a[1] = 32'd9; req_b[1] = 32'd3; req_val[1] = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (resp_val[0]) got = 1;
            else begin @(posedge clk); @(negedge clk); end
        end
        chk("bp_resp", 64'(got), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk); #1;
            chk($sformatf("bp%0d_val", i), 64'(resp_val), 64'(2'b01));
            chk($sformatf("bp%0d_res", i), resp_res[0], {32'd2, 32'd14});
            chk($sformatf("bp%0d_req_rdy", i), 64'(req_rdy), 64'd0);
        end
        resp_rdy[0] = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk("bp_next_grant", 64'(req_rdy), 64'(2'b10));
        @(posedge clk); @(negedge clk);
        req_val[1] = 1'b0;
        wait_resp(1, {32'd0, 32'd3}, "bp_p1");

        // Divide by zero.
        dq_snap = divreq_cnt;
        send(0, 1'b0, 32'd5, 32'd0, "dz");
        wait_resp(0, {32'd5, 32'hFFFF_FFFF}, "dz");
`ifdef IMULDIV_DIV_ARB_DIVZERO_BYPASS_EN
        chk("dz_divreq_untouched", 64'(divreq_cnt - dq_snap), 64'd0);
`else
        chk("dz_divreq_used", 64'(divreq_cnt != dq_snap), 64'd1);
`endif

        // Reset while waiting on the divider.
        send(0, 1'b0, 32'd20, 32'd3, "rw");
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (divresp_rdy) got = 1;
            else begin @(posedge clk); @(negedge clk); end
        end
        chk("rw_in_wait", 64'(got), 64'd1);
        reset = 1'b1;
        #1 chk_quiet("rw_during_reset");
        @(posedge clk); @(negedge clk); #1;
        chk_quiet("rw_after_reset");
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_busy_cycles", 64'(busy_cycles), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        send(1, 1'b0, 32'd20, 32'd3, "rw_new");
        wait_resp(1, {32'd2, 32'd6}, "rw_new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
